uart_frame_parser: RTL and testbench
====================================

Name: uart_frame_parser

Overview:
- Consumes bytes from the UART receive FIFO through its read side (RxEmpty/ReadUart/ReadData) and extracts framed packets of the form SOF, LEN, LEN payload bytes, CHK.
- Buffers each payload internally and releases it on a valid/ready stream only after the checksum passes.
- Sits directly downstream of the UART top level and feeds command-decode logic.

Parameters:
- DATA_BITS, 8, byte width; must match the UART.
- SOF_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 16, maximum payload length in bytes; legal range 1..255.
- TIMEOUT_CYCLES, 100000, inter-byte timeout in Clock cycles while a frame is in progress.

Ports:
- Clock  in  1  system clock (50 MHz).
- ResetN  in  1  asynchronous, active-low reset.
- RxEmpty  in  1  UART RX FIFO empty.
- ReadData  in  DATA_BITS  UART RX FIFO head byte; valid whenever RxEmpty=0 (first-word-fall-through).
- ReadUart  out  1  pop strobe to the UART RX FIFO.
- PayloadData  out  DATA_BITS  payload byte.
- PayloadValid  out  1  PayloadData is valid.
- PayloadReady  in  1  consumer accepts the byte.
- PayloadLast  out  1  marks the final byte of the frame.
- FrameDone  out  1  one-cycle pulse when a frame is fully drained.
- FrameError  out  1  one-cycle pulse when a frame is rejected.
- ErrorCode  out  2  cause of the last error: 0 none, 1 bad LEN, 2 checksum, 3 timeout.

Behaviour:
- Reset: one clock; ResetN is asynchronous, active-low. All outputs go to 0, state goes to IDLE, and all counters clear. Buffer contents are don't-care. Reset mid-frame or mid-drain abandons the frame with no FrameDone/FrameError pulse.
- Pop rule: ReadUart = ~RxEmpty and state in {IDLE, LEN, PAYLOAD, CHECK}. ReadUart is combinational, at most one byte per cycle. A byte is consumed at the rising edge where ReadUart=1. ReadUart is never asserted in DRAIN, which back-pressures the UART FIFO.
- IDLE: a popped byte equal to SOF_BYTE moves to LEN. Any other byte is discarded silently with no error.
- LEN: the popped byte is stored as len and the running sum is set to len.
  - len=0 or len>MAX_LEN: FrameError pulse, ErrorCode=1, go to IDLE.
  - Otherwise: write index cleared, go to PAYLOAD.
- PAYLOAD: each popped byte is written to buf[wr_idx], added to the sum (mod 256), and wr_idx is incremented. When wr_idx reaches len-1, go to CHECK.
- CHECK: the popped byte is added to the sum.
  - Sum == 8'h00: go to DRAIN with rd_idx=0.
  - Otherwise: FrameError pulse, ErrorCode=2, go to IDLE.
  - CHK is therefore the two's complement of (LEN + payload) mod 256.
- Timeout: the counter runs in LEN, PAYLOAD and CHECK, and resets on every pop and on entry to LEN. When it reaches TIMEOUT_CYCLES: FrameError pulse, ErrorCode=3, go to IDLE. The next byte is treated as a hunt for SOF.
- DRAIN:
  - PayloadValid=1, PayloadData=buf[rd_idx], PayloadLast=(rd_idx==len-1), all registered or from state.
  - The first byte is valid in the cycle after the edge that popped CHK, giving latency 1 from the CHK pop.
  - A transfer occurs on PayloadValid & PayloadReady, after which rd_idx increments.
  - Data is held stable while PayloadReady=0; there is no timeout in DRAIN.
  - On the last transfer: FrameDone pulses in the next cycle, state goes to IDLE, and PayloadValid drops in the same next cycle.
- SOF_BYTE appearing inside LEN, PAYLOAD or CHECK is treated as data; there is no resynchronisation mid-frame.
- ErrorCode holds its value until the next FrameError or reset. FrameDone does not clear it.
- Counter widths: wr_idx and rd_idx use $clog2(MAX_LEN) (minimum 1); the timeout counter uses $clog2(TIMEOUT_CYCLES+1).
- Sustained throughput is one byte per cycle when the FIFO is non-empty. Idle gaps between bytes are legal.

Decomposition:
- Package uart_frame_pkg holds:
  - state enum: IDLE, LEN, PAYLOAD, CHECK, DRAIN;
  - error code constants: ERR_NONE, ERR_LEN, ERR_CHK, ERR_TIMEOUT;
  - default SOF_BYTE.
- Sub-module uart_frame_buffer: MAX_LEN x DATA_BITS register file with synchronous write port (WrEn, WrAddr, WrData) and asynchronous read port (RdAddr, RdData).
- The FSM, counters and checksum stay in the top.

Test Plan:
- Good frame: A5 02 11 22 CB fed via a FIFO model with PayloadReady=1 -> PayloadData 11 then 22, PayloadLast on 22, one FrameDone pulse, ErrorCode stays 0.
- Garbage then frame: 00 FF A5 01 7E 81 -> the 00 and FF are popped silently; payload 7E with PayloadLast; FrameDone; no FrameError.
- Bad checksum: A5 02 11 22 CC -> FrameError pulse, ErrorCode=2, PayloadValid never asserts. A following good frame is then accepted.
- Bad length: A5 00, then A5 11 with MAX_LEN=16 -> two FrameError pulses, ErrorCode=1, state returns to IDLE each time.
- Timeout with TIMEOUT_CYCLES=100: A5 03 11 then RxEmpty held high 100 cycles -> FrameError, ErrorCode=3. The next frame A5 01 05 FA delivers 05.
- Back-pressure: good 4-byte frame with PayloadReady toggling 0/1 and a second frame queued in the FIFO -> bytes are delivered in order and stable while stalled, ReadUart=0 throughout DRAIN, and the second frame is parsed only after FrameDone.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser: FSM states, error
// codes and the default start-of-frame marker.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHECK,
        DRAIN
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEF_SOF_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_buffer.sv
// Payload store: DEPTH x DATA_BITS register file, synchronous write and
// asynchronous read so the drain side presents data straight from rd_idx.
module uart_frame_buffer #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4
) (
    input  logic                 Clock,
    input  logic                 WrEn,
    input  logic [ADDR_W-1:0]    WrAddr,
    input  logic [DATA_BITS-1:0] WrData,
    input  logic [ADDR_W-1:0]    RdAddr,
    output logic [DATA_BITS-1:0] RdData
);

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    // No reset: contents are only ever read after being written by a frame.
    always_ff @(posedge Clock) begin
        if (WrEn) mem_q[WrAddr] <= WrData;
    end

    assign RdData = mem_q[RdAddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Pulls SOF/LEN/payload/CHK frames out of the UART RX FIFO, verifies the
// checksum and only then streams the buffered payload out on valid/ready.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int                   DATA_BITS      = 8,
    parameter logic [DATA_BITS-1:0] SOF_BYTE       = DATA_BITS'(DEF_SOF_BYTE),
    parameter int                   MAX_LEN        = 16,
    parameter int                   TIMEOUT_CYCLES = 100000
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 RxEmpty,
    input  logic [DATA_BITS-1:0] ReadData,
    output logic                 ReadUart,
    output logic [DATA_BITS-1:0] PayloadData,
    output logic                 PayloadValid,
    input  logic                 PayloadReady,
    output logic                 PayloadLast,
    output logic                 FrameDone,
    output logic                 FrameError,
    output logic [1:0]           ErrorCode
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]     TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [DATA_BITS-1:0] LEN_MAX = DATA_BITS'(MAX_LEN);

    state_e                 state_q, state_d;
    logic [DATA_BITS-1:0]   len_q, len_d;
    logic [DATA_BITS-1:0]   sum_q, sum_d;
    logic [IDX_W-1:0]       wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [1:0]             err_code_q, err_code_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   pop;
    logic                   in_frame;
    logic                   buf_we;
    logic [DATA_BITS-1:0]   buf_rdata;
    logic [DATA_BITS-1:0]   sum_nxt;
    logic [DATA_BITS-1:0]   len_m1;
    logic                   wr_last;
    logic                   rd_last;

    // DRAIN never pops, which back-pressures the UART FIFO while the
    // consumer stalls.
    assign pop      = ~RxEmpty & (state_q != DRAIN);
    assign in_frame = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHECK);
    assign sum_nxt  = sum_q + ReadData;
    assign len_m1   = len_q - DATA_BITS'(1);
    assign wr_last  = (DATA_BITS'(wr_idx_q) == len_m1);
    assign rd_last  = (DATA_BITS'(rd_idx_q) == len_m1);

    uart_frame_buffer #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (MAX_LEN),
        .ADDR_W    (IDX_W)
    ) u_buf (
        .Clock  (Clock),
        .WrEn   (buf_we),
        .WrAddr (wr_idx_q),
        .WrData (ReadData),
        .RdAddr (rd_idx_q),
        .RdData (buf_rdata)
    );

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= IDLE;
            len_q      <= '0;
            sum_q      <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            tmo_q      <= '0;
            err_code_q <= ERR_NONE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            tmo_q      <= tmo_d;
            err_code_q <= err_code_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        sum_d      = sum_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        tmo_d      = tmo_q;
        err_code_d = err_code_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        buf_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop && ReadData == SOF_BYTE) begin
                    state_d = LEN;
                    tmo_d   = '0;
                end
            end
            LEN: begin
                if (pop) begin
                    len_d = ReadData;
                    sum_d = ReadData;
                    tmo_d = '0;
                    if (ReadData == '0 || ReadData > LEN_MAX) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = IDLE;
                    end else begin
                        wr_idx_d = '0;
                        state_d  = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (pop) begin
                    buf_we = 1'b1;
                    sum_d  = sum_nxt;
                    tmo_d  = '0;
                    if (wr_last) state_d  = CHECK;
                    else         wr_idx_d = wr_idx_q + IDX_W'(1);
                end
            end
            CHECK: begin
                if (pop) begin
                    sum_d = sum_nxt;
                    tmo_d = '0;
                    if (sum_nxt == '0) begin
                        rd_idx_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CHK;
                        state_d    = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (PayloadReady) begin
                    if (rd_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Inter-byte timeout; a pop in the same cycle always wins.
        if (in_frame && !pop) begin
            if (tmo_q == TMO_MAX) begin
                err_d      = 1'b1;
                err_code_d = ERR_TIMEOUT;
                state_d    = IDLE;
                tmo_d      = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    assign ReadUart     = pop;
    assign PayloadValid = (state_q == DRAIN);
    assign PayloadData  = PayloadValid ? buf_rdata : '0;
    assign PayloadLast  = PayloadValid & rd_last;
    assign FrameDone    = done_q;
    assign FrameError   = err_q;
    assign ErrorCode    = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: FIFO model on the read side, payload
// scoreboard on the stream side, table of frames plus corner-case sequences.
module tb_uart_frame_parser;

    logic       Clock = 1'b0;
    logic       ResetN = 1'b0;
    logic       RxEmpty = 1'b1;
    logic [7:0] ReadData = 8'h00;
    logic       ReadUart;
    logic [7:0] PayloadData;
    logic       PayloadValid;
    logic       PayloadReady = 1'b1;
    logic       PayloadLast;
    logic       FrameDone;
    logic       FrameError;
    logic [1:0] ErrorCode;

    uart_frame_parser #(
        .DATA_BITS      (8),
        .SOF_BYTE       (8'hA5),
        .MAX_LEN        (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .Clock        (Clock),
        .ResetN       (ResetN),
        .RxEmpty      (RxEmpty),
        .ReadData     (ReadData),
        .ReadUart     (ReadUart),
        .PayloadData  (PayloadData),
        .PayloadValid (PayloadValid),
        .PayloadReady (PayloadReady),
        .PayloadLast  (PayloadLast),
        .FrameDone    (FrameDone),
        .FrameError   (FrameError),
        .ErrorCode    (ErrorCode)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        logic [63:0] bytes;   // byte k at bits [8k+7:8k]
        int          n;
        int          pay_off;
        int          pay_n;
        int          exp_done;
        int          exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    logic [7:0] fifo [$];
    exp_t       exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic       pop_seen = 1'b0;
    logic       bp_mode = 1'b0;
    logic       bp_done_seen = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic       hold_last = 1'b0;
    vec_t       vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fifo_refresh();
        RxEmpty  = (fifo.size() == 0);
        ReadData = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo.push_back(b);
        fifo_refresh();
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        for (int c = 0; c < 1000 && quiet < 4; c++) begin
            @(posedge Clock); #1;
            if (fifo.size() == 0 && !PayloadValid && exp_q.size() == 0) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) begin
            checks++;
            errors++;
            $display("FAIL %s: still busy after cycle bound, expected idle", name);
        end
    endtask

    always @(posedge Clock) pop_seen <= ReadUart;

    // FIFO pop, pulse counting and payload scoreboard, all away from the edge.
    always @(negedge Clock) begin
        exp_t e;
        if (pop_seen && fifo.size() > 0) void'(fifo.pop_front());
        fifo_refresh();
        if (ResetN) begin
            if (FrameDone) begin
                done_cnt++;
                if (bp_mode && !bp_done_seen) begin
                    chk("second_frame_untouched", fifo.size(), 4);
                    bp_done_seen = 1'b1;
                end
            end
            if (FrameError) err_cnt++;
            if (PayloadValid) begin
                chk("no_pop_in_drain", ReadUart, 0);
                if (stall) begin
                    chk("stall_data", PayloadData, hold_data);
                    chk("stall_last", PayloadLast, hold_last);
                end
                if (PayloadReady) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_payload: got %0h expected none", PayloadData);
                    end else begin
                        e = exp_q.pop_front();
                        chk("payload_data", PayloadData, e.data);
                        chk("payload_last", PayloadLast, e.last);
                    end
                end
            end
        end
        stall     = PayloadValid && !PayloadReady;
        hold_data = PayloadData;
        hold_last = PayloadLast;
    end

    initial begin
        forever begin
            @(posedge Clock); #1;
            if (bp_mode) PayloadReady = ~PayloadReady;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected summary");
        $fatal(1);
    end

    initial begin
        int d0, e0, n;

        vt[0] = '{64'h000000CB221102A5, 5, 2, 2, 1, 0, 2'd0};  // good frame
        vt[1] = '{64'h0000817E01A5FF00, 6, 4, 1, 1, 0, 2'd0};  // garbage then frame
        vt[2] = '{64'h000000CC221102A5, 5, 0, 0, 0, 1, 2'd2};  // bad checksum
        vt[3] = '{64'h00000000FA0501A5, 4, 2, 1, 1, 0, 2'd2};  // good; code held
        vt[4] = '{64'h00000000000000A5 | 64'h0000, 2, 0, 0, 0, 1, 2'd1};  // LEN=0
        vt[5] = '{64'h00000000000011A5, 2, 0, 0, 0, 1, 2'd1};  // LEN=17
        vt[6] = '{64'h000000B4A5A502A5, 5, 2, 2, 1, 0, 2'd1};  // SOF as payload

        repeat (3) @(posedge Clock);
        #1;
        chk("rst_valid", PayloadValid, 0);
        chk("rst_data", PayloadData, 0);
        chk("rst_last", PayloadLast, 0);
        chk("rst_done", FrameDone, 0);
        chk("rst_error", FrameError, 0);
        chk("rst_code", ErrorCode, 0);
        chk("rst_read", ReadUart, 0);
        ResetN = 1'b1;
        repeat (2) @(posedge Clock);
        #1;

        for (int i = 0; i < 7; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            for (int k = 0; k < vt[i].pay_n; k++)
                exp_q.push_back('{data: vt[i].bytes[8*(vt[i].pay_off+k) +: 8],
                                  last: (k == vt[i].pay_n - 1)});
            for (int k = 0; k < vt[i].n; k++) push_byte(vt[i].bytes[8*k +: 8]);
            wait_idle($sformatf("v%0d_idle", i));
            chk($sformatf("v%0d_done", i), done_cnt - d0, vt[i].exp_done);
            chk($sformatf("v%0d_err", i), err_cnt - e0, vt[i].exp_err);
            chk($sformatf("v%0d_code", i), ErrorCode, vt[i].exp_code);
        end

        // Maximum length: 16 bytes 00..0F, CHK = -(0x10 + 0x78) = 0x78.
        d0 = done_cnt;
        e0 = err_cnt;
        for (int k = 0; k < 16; k++) exp_q.push_back('{data: 8'(k), last: (k == 15)});
        push_byte(8'hA5);
        push_byte(8'h10);
        for (int k = 0; k < 16; k++) push_byte(8'(k));
        push_byte(8'h78);
        wait_idle("maxlen_idle");
        chk("maxlen_done", done_cnt - d0, 1);
        chk("maxlen_err", err_cnt - e0, 0);

        // Timeout mid-payload, then a clean frame.
        d0 = done_cnt;
        e0 = err_cnt;
        push_byte(8'hA5);
        push_byte(8'h03);
        push_byte(8'h11);
        n = 0;
        while (fifo.size() != 0 && n < 50) begin
            @(posedge Clock); #1;
            n++;
        end
        n = 0;
        while (err_cnt == e0 && n < 400) begin
            @(posedge Clock); #1;
            n++;
        end
        chk("timeout_window", (n >= 98 && n <= 104), 1);
        chk("timeout_err", err_cnt - e0, 1);
        chk("timeout_code", ErrorCode, 3);
        chk("timeout_done", done_cnt - d0, 0);
        exp_q.push_back('{data: 8'h05, last: 1'b1});
        push_byte(8'hA5);
        push_byte(8'h01);
        push_byte(8'h05);
        push_byte(8'hFA);
        wait_idle("post_timeout_idle");
        chk("post_timeout_done", done_cnt - d0, 1);

        // Back-pressure with a second frame queued behind the first.
        d0 = done_cnt;
        e0 = err_cnt;
        bp_mode = 1'b1;
        for (int k = 1; k <= 4; k++) exp_q.push_back('{data: 8'(k), last: (k == 4)});
        exp_q.push_back('{data: 8'h05, last: 1'b1});
        push_byte(8'hA5); push_byte(8'h04);
        for (int k = 1; k <= 4; k++) push_byte(8'(k));
        push_byte(8'hF2);
        push_byte(8'hA5); push_byte(8'h01); push_byte(8'h05); push_byte(8'hFA);
        wait_idle("bp_idle");
        bp_mode = 1'b0;
        PayloadReady = 1'b1;
        chk("bp_done", done_cnt - d0, 2);
        chk("bp_err", err_cnt - e0, 0);
        chk("bp_first_done_seen", bp_done_seen, 1);

        // Reset while a frame is waiting in DRAIN: abandoned, no pulses.
        PayloadReady = 1'b0;
        push_byte(8'hA5); push_byte(8'h01); push_byte(8'h05); push_byte(8'hFA);
        n = 0;
        while (!PayloadValid && n < 50) begin
            @(posedge Clock); #1;
            n++;
        end
        chk("rst_drain_reached", PayloadValid, 1);
        d0 = done_cnt;
        e0 = err_cnt;
        ResetN = 1'b0;
        #1;
        chk("rst_drain_valid", PayloadValid, 0);
        chk("rst_drain_code", ErrorCode, 0);
        repeat (2) @(posedge Clock);
        #1;
        ResetN = 1'b1;
        PayloadReady = 1'b1;
        repeat (6) @(posedge Clock);
        #1;
        chk("rst_drain_no_done", done_cnt - d0, 0);
        chk("rst_drain_no_err", err_cnt - e0, 0);
        chk("rst_drain_idle", PayloadValid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
